// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the MIPS EX stage. Executes mult, multu,
// div and divu on 32-bit operands, one result bit per cycle (32-cycle
// shift-add multiply or restoring divide, then one fix-up cycle that applies
// signs and writes HI/LO). Owns the architectural HI/LO registers and holds
// the pipeline with a combinational stall while an operation is in flight.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     operation request from the instruction in EX
//   op        00 mult, 01 multu, 10 div, 11 divu
//   a         rs operand (multiplicand / dividend)
//   b         rt operand (multiplier / divisor)
//   wr_hi     mthi write enable (honoured only while idle)
//   wr_lo     mtlo write enable (honoured only while idle)
//   wr_data   mthi/mtlo write data
//   hi        HI register (product high word / remainder)
//   lo        LO register (product low word / quotient)
//   busy      operation in flight
//   done      one-cycle completion pulse, coincides with updated HI/LO
//   stall     holds IF/ID/EX while an operation is pending or running
//   div_zero  last divide had a zero divisor; sticky until the next accept
// -----------------------------------------------------------------------------
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;

    // Latched operation context
    logic [5:0]  count;
    logic        opIsDiv;
    logic        opIsSigned;
    logic        signA;
    logic        signB;
    logic        divZeroPend;
    logic [31:0] magA;          // |a|, or raw a for a divide by zero
    logic [31:0] magB;          // |b|

    // Shared 64-bit working register:
    //   multiply: {partial product, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits / quotient bits}
    logic [63:0] acc;

    // Request decode
    logic        accept;
    logic        reqDiv;
    logic        reqSigned;
    logic        reqBZero;
    logic [31:0] absA;
    logic [31:0] absB;

    // One-bit iteration steps
    logic [32:0] mulSum;
    logic [63:0] mulNext;
    logic [64:0] divShift;
    logic [32:0] divTrial;
    logic [63:0] divNext;

    // Sign fix-up and writeback values
    logic [63:0] prodFixed;
    logic [31:0] quoFixed;
    logic [31:0] remFixed;
    logic [31:0] fixHi;
    logic [31:0] fixLo;

    // -------------------------------------------------------------------------
    // Request decode. A start is only taken in IDLE outside the done cycle, so
    // the instruction that was just released by stall is not executed twice.
    // -------------------------------------------------------------------------
    assign accept    = (state == IDLE) && start && !done;
    assign reqDiv    = op[1];
    assign reqSigned = !op[0];
    assign reqBZero  = (b == 32'd0);
    assign absA      = (reqSigned && a[31]) ? (32'd0 - a) : a;
    assign absB      = (reqSigned && b[31]) ? (32'd0 - b) : b;

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign busy  = (state != IDLE);
    assign stall = busy || (start && !done);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // A zero divisor has a fixed result, so skip the iterations.
                    nextState = (reqDiv && reqBZero) ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == 6'd31) begin
                    nextState = FIX;
                end
            end
            FIX: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Multiply step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole register right by one. The
    // 33-bit sum keeps the carry, which becomes bit 63 after the shift.
    // -------------------------------------------------------------------------
    always_comb begin
        mulSum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? magA : 32'd0)};
        mulNext = {mulSum, acc[31:1]};
    end

    // -------------------------------------------------------------------------
    // Restoring divide step: shift remainder:quotient left, trial-subtract the
    // divisor from the 33-bit shifted remainder. A clear bit 32 means no borrow:
    // keep the difference and shift in a quotient 1; otherwise keep the shifted
    // value (quotient bit 0). The shifted remainder is below 2*divisor, so 33
    // bits are enough for both outcomes.
    // -------------------------------------------------------------------------
    always_comb begin
        divShift = {acc, 1'b0};
        divTrial = divShift[64:32] - {1'b0, magB};
        if (divTrial[32]) begin
            divNext = divShift[63:0];
        end else begin
            divNext = {divTrial[31:0], divShift[31:1], 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // Sign fix-up. Quotient is negative when the operand signs differ, the
    // remainder follows the dividend. 0x8000_0000 / -1 falls out naturally:
    // magnitude quotient 0x8000_0000 negates to itself, remainder 0.
    // -------------------------------------------------------------------------
    always_comb begin
        prodFixed = acc;
        quoFixed  = acc[31:0];
        remFixed  = acc[63:32];
        if (opIsSigned && (signA ^ signB)) begin
            prodFixed = 64'd0 - acc;
            quoFixed  = 32'd0 - acc[31:0];
        end
        if (opIsSigned && signA) begin
            remFixed = 32'd0 - acc[63:32];
        end

        if (divZeroPend) begin
            fixHi = magA;
            fixLo = 32'hFFFF_FFFF;
        end else if (opIsDiv) begin
            fixHi = remFixed;
            fixLo = quoFixed;
        end else begin
            fixHi = prodFixed[63:32];
            fixLo = prodFixed[31:0];
        end
    end

    // -------------------------------------------------------------------------
    // State, datapath and HI/LO registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            count       <= 6'd0;
            opIsDiv     <= 1'b0;
            opIsSigned  <= 1'b0;
            signA       <= 1'b0;
            signB       <= 1'b0;
            divZeroPend <= 1'b0;
            magA        <= 32'd0;
            magB        <= 32'd0;
            acc         <= 64'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            state <= nextState;
            done  <= (state == FIX);

            case (state)
                IDLE: begin
                    // mthi/mtlo land only while idle, including the done cycle.
                    if (wr_hi) begin
                        hi <= wr_data;
                    end
                    if (wr_lo) begin
                        lo <= wr_data;
                    end

                    if (accept) begin
                        opIsDiv     <= reqDiv;
                        opIsSigned  <= reqSigned;
                        signA       <= reqSigned && a[31];
                        signB       <= reqSigned && b[31];
                        divZeroPend <= reqDiv && reqBZero;
                        magA        <= (reqDiv && reqBZero) ? a : absA;
                        magB        <= absB;
                        count       <= 6'd0;
                        div_zero    <= 1'b0;
                        // Divide starts from the dividend, multiply from the
                        // multiplier; the upper half starts cleared either way.
                        acc         <= reqDiv ? {32'd0, absA} : {32'd0, absB};
                    end
                end

                CALC: begin
                    acc   <= opIsDiv ? divNext : mulNext;
                    count <= count + 6'd1;
                end

                FIX: begin
                    hi       <= fixHi;
                    lo       <= fixLo;
                    div_zero <= divZeroPend;
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit: reset state, a table of directed
// vectors, hand-written sequences for held/repeated start, mthi/mtlo while
// busy and idle, reset mid-operation, and randomized operations compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wrHi;
    logic        wrLo;
    logic [31:0] wrData;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;
    logic        divZero;

    int checks = 0;
    int errors = 0;

    localparam int LAT_NORMAL = 34;
    localparam int LAT_DIVZ   = 2;
    localparam int MAX_WAIT   = 200;

    mult_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .wr_hi    (wrHi),
        .wr_lo    (wrLo),
        .wr_data  (wrData),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .div_zero (divZero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on widened operands.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint      sx;
        longint      sy;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        h  = '0;
        l  = '0;
        if (o[1] && y == 32'd0) begin
            h  = x;
            l  = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            case (o)
                2'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
                2'd1: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
                2'd2: begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
                default: begin l = x / y; h = x % y; end
            endcase
        end
    endfunction

    // Issue one single-cycle start and check latency, busy span, stall and result.
    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz, input int expLat);
        int cycles;
        int busyCycles;
        int stallLow;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        #1;
        check($sformatf("%s stall on request", name), stall, 1);
        @(negedge clk);
        start      = 1'b0;
        cycles     = 1;
        busyCycles = 0;
        stallLow   = 0;
        while (done !== 1'b1 && cycles < MAX_WAIT) begin
            if (busy === 1'b1) busyCycles++;
            if (stall !== 1'b1) stallLow++;
            @(negedge clk);
            cycles++;
        end
        check($sformatf("%s latency", name), cycles, expLat);
        check($sformatf("%s busy cycles", name), busyCycles, expLat - 1);
        check($sformatf("%s stall gaps", name), stallLow, 0);
        check($sformatf("%s busy at done", name), busy, 0);
        check($sformatf("%s hi", name), hi, expHi);
        check($sformatf("%s lo", name), lo, expLo);
        check($sformatf("%s div_zero", name), divZero, expDz);
        @(negedge clk);
        check($sformatf("%s done width", name), done, 0);
    endtask

    initial begin
        logic [31:0] mHi;
        logic [31:0] mLo;
        logic        mDz;
        int          cycles;
        int          sawDone;

        rst = 1'b1; start = 1'b1; op = 2'd0; a = 32'd0; b = 32'd0;
        wrHi = 1'b0; wrLo = 1'b0; wrData = 32'd0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", divZero, 0);
        check("reset stall follows start", stall, 1);
        start = 1'b0;
        #1;
        check("reset stall low", stall, 0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        vecs.push_back('{"mult -3*5",      2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, LAT_NORMAL});
        vecs.push_back('{"multu max*max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_NORMAL});
        vecs.push_back('{"mult -1*-1",     2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, LAT_NORMAL});
        vecs.push_back('{"div -7/2",       2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT_NORMAL});
        vecs.push_back('{"div 7/-2",       2'd2, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, LAT_NORMAL});
        vecs.push_back('{"divu 7/2",       2'd3, 32'd7,        32'd2,        32'd1,         32'd3,         1'b0, LAT_NORMAL});
        vecs.push_back('{"div ovf",        2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, LAT_NORMAL});
        vecs.push_back('{"divu max/1",     2'd3, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, LAT_NORMAL});
        vecs.push_back('{"divu 5/7",       2'd3, 32'd5,        32'd7,        32'd5,         32'd0,         1'b0, LAT_NORMAL});
        vecs.push_back('{"div by zero",    2'd2, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1, LAT_DIVZ});
        vecs.push_back('{"multu clears dz",2'd1, 32'd3,        32'd4,        32'd0,         32'd12,        1'b0, LAT_NORMAL});
        vecs.push_back('{"divu by zero",   2'd3, 32'h8765_4321, 32'd0,        32'h8765_4321, 32'hFFFF_FFFF, 1'b1, LAT_DIVZ});

        for (int i = 0; i < vecs.size(); i++) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
        end

        // ---------------- start held high, operands changed mid-flight ----------------
        @(negedge clk);
        op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        cycles = 1;
        while (done !== 1'b1 && cycles < MAX_WAIT) begin
            if (cycles == 10) begin
                op = 2'd2; a = 32'd99; b = 32'd99;
            end
            @(negedge clk);
            cycles++;
        end
        check("held latency", cycles, LAT_NORMAL);
        check("held lo", lo, 42);
        check("held hi", hi, 0);
        check("held stall in done", stall, 0);
        @(negedge clk);
        check("held not re-accepted", busy, 0);
        start = 1'b0;

        // ---------------- mid-op start pulse and mthi while busy ----------------
        @(negedge clk);
        op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < MAX_WAIT) begin
            if (cycles == 12) begin
                start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
            end else if (cycles == 13) begin
                start = 1'b0;
            end
            if (cycles == 15) begin
                wrHi = 1'b1; wrData = 32'hAAAA_AAAA;
            end else if (cycles == 16) begin
                wrHi = 1'b0;
                check("mthi while busy ignored", hi, 0);
            end
            @(negedge clk);
            cycles++;
        end
        check("pulse latency", cycles, LAT_NORMAL);
        check("pulse lo", lo, 14);
        check("pulse hi", hi, 2);
        @(negedge clk);
        check("pulse no second op", busy, 0);

        // ---------------- mthi/mtlo while idle ----------------
        wrHi = 1'b1; wrData = 32'hAAAA_AAAA;
        @(negedge clk);
        wrHi = 1'b0;
        check("mthi idle", hi, 32'hAAAA_AAAA);
        wrLo = 1'b1; wrData = 32'h5555_5555;
        @(negedge clk);
        wrLo = 1'b0;
        check("mtlo idle", lo, 32'h5555_5555);
        check("mtlo keeps hi", hi, 32'hAAAA_AAAA);

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        op = 2'd0; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-abort busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        sawDone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) sawDone++;
            @(negedge clk);
        end
        check("abort no done", sawDone, 0);
        runOp("after abort", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, LAT_NORMAL);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 17));
                default: ;
            endcase
            model(ro, ra, rb, mHi, mLo, mDz);
            runOp($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, mHi, mLo, mDz,
                  (ro[1] && rb == 32'd0) ? LAT_DIVZ : LAT_NORMAL);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS pipeline's EX stage. It executes mult, multu, div and divu on 32-bit operands with a shift-add / restoring-divide engine over 32 cycles. It owns the architectural HI/LO registers and raises a stall to hold the pipeline while an operation is in flight. It sits beside the ALU, and its op encoding is produced by the main controller.

## Interface
- No parameters; the datapath width is fixed at 32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request from the instruction in EX.
- op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- a  input  32  operand rs (multiplicand / dividend).
- b  input  32  operand rt (multiplier / divisor).
- wr_hi  input  1  mthi write enable.
- wr_lo  input  1  mtlo write enable.
- wr_data  input  32  mthi/mtlo data.
- hi  output  32  HI register (product high word / remainder).
- lo  output  32  LO register (product low word / quotient).
- busy  output  1  operation in flight.
- done  output  1  one-cycle completion pulse.
- stall  output  1  combinational; holds IF/ID/EX.
- div_zero  output  1  last divide had b == 0; sticky until the next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start is accepted only when state is IDLE and done is 0.
  - On accept, latch op and operand magnitudes. For signed ops, |a| and |b| with the sign bits saved; for unsigned ops, the raw values.
  - Clear the 6-bit counter and div_zero, then go to CALC.
  - Exception: a divide with b == 0 goes straight to FIX.
- CALC:
  - One bit per cycle.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring divide, shift remainder:quotient left, trial-subtract the divisor.
  - The counter increments each cycle. After the 32nd CALC cycle (counter = 31), go to FIX.
- FIX, signed multiply: negate the 64-bit product if sa ^ sb.
- FIX, signed divide:
  - Quotient is negative if sa ^ sb; remainder takes the sign of sa.
  - All negation is two's complement mod 2^32 (or mod 2^64 for the product).
- FIX, writeback:
  - Multiply: {hi,lo} = product.
  - Divide: lo = quotient, hi = remainder.
  - Divide by zero: hi = a (raw), lo = 32'hFFFF_FFFF, div_zero = 1.
  - Go to IDLE and assert done for the next cycle.
- Overflow case 0x8000_0000 / -1 (signed): lo = 0x8000_0000, hi = 0; no trap.
- busy = (state != IDLE).
- stall = busy | (start & ~done).
  - The issuing instruction is held until the done cycle, then advances. Its start is not re-accepted in that cycle.
- mthi/mtlo:
  - wr_hi / wr_lo update hi / lo at the clock edge only when busy = 0.
  - Writes are ignored while busy.
  - A FIX writeback has priority over a same-edge write; that case cannot occur because busy = 1 in FIX.
- start while busy: ignored, with no effect on the latched operands.

## Timing
- Reset (synchronous): state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, counter = 0. stall = start.
- rst asserted mid-operation: aborts at that edge. No done pulse; hi/lo are cleared to 0.
- Normal latency (start sampled at edge E0):
  - busy = 1 after E0 through E0+33 (32 CALC cycles + 1 FIX cycle).
  - hi/lo are updated and done = 1 in the cycle after edge E0+33.
  - 34 cycles from the start edge to done high.
- Divide-by-zero latency: FIX follows E0 directly. done is high in the cycle after E0+1 (2 cycles).
- done is high for exactly one cycle. busy = 0 during done.
- Back-to-back operations: a new start is accepted at the first edge after the done cycle (minimum one-cycle gap).
- Outputs hi/lo are registered and stable except at the FIX edge or an mthi/mtlo edge.

## Test plan
- mult a = 0xFFFF_FFFD (-3), b = 5, start for 1 cycle -> busy = 1 for 33 cycles, done pulse 34 cycles after the start edge, hi = 0xFFFF_FFFF, lo = 0xFFFF_FFF1, stall high from the start cycle until done.
- multu a = b = 0xFFFF_FFFF -> hi = 0xFFFF_FFFE, lo = 0x0000_0001; mult on the same operands -> hi = 0, lo = 1.
- div a = -7, b = 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF; divu a = 7, b = 2 -> lo = 3, hi = 1; div 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0.
- div a = 0x1234, b = 0 -> done 2 cycles after the start edge, hi = 0x1234, lo = 0xFFFF_FFFF, div_zero = 1. A following multu clears div_zero on accept.
- Holding start high through the operation -> exactly one operation executes; stall drops in the done cycle. A second start pulsed mid-operation changes nothing. wr_hi with 0xAAAA_AAAA while busy -> ignored; while idle -> hi = 0xAAAA_AAAA next cycle.
- rst asserted at cycle 10 of a mult -> next cycle busy = 0, hi = lo = 0, no done pulse. A new start afterwards completes normally with the 34-cycle latency.
